acc_chain: RTL and testbench

ACC_CHAIN -- requirements
Module: acc_chain

---
 rtl/acc_chain.sv | 83 ++++++++
 tb/tb_acc_chain.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/acc_chain.sv
// Cascaded accumulator chain: each stage integrates the (possibly clamped) sum of the
// stage below it, with the full ripple resolved inside one clock cycle.
module acc_chain #(
    parameter int DIN_W  = 4,
    parameter int ACC_W  = 8,
    parameter int STAGES = 3,
    parameter int SAT    = 0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    input  logic [DIN_W-1:0]                             data,
    input  logic                                         clr,
    input  logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] sel,
    output logic [ACC_W-1:0]                             out,
    output logic                                         out_valid,
    output logic [STAGES-1:0]                            ovf
);

    // Valid semantics: in_valid is a one-cycle strobe with no backpressure; every cycle
    // it is high (and clr is low) one sample is absorbed, and out_valid is high on the
    // following cycle to mark that the stage registers changed on that edge.

    logic [ACC_W-1:0]  r_acc [STAGES];
    logic [STAGES-1:0] r_ovf;
    logic              r_out_valid;

    logic [ACC_W-1:0]  w_next [STAGES];
    logic [STAGES-1:0] w_carry;

    // The running operand carries each stage's result (clamped when SAT=1) into the next.
    always_comb begin
        logic [ACC_W-1:0] v_run;
        logic [ACC_W:0]   v_full;
        v_run   = {{(ACC_W-DIN_W){1'b0}}, data};
        w_carry = '0;
        for (int k = 0; k < STAGES; k++) begin
            v_full     = {1'b0, r_acc[k]} + {1'b0, v_run};
            w_carry[k] = v_full[ACC_W];
            if ((SAT != 0) && v_full[ACC_W]) begin
                w_next[k] = '1;
            end else begin
                w_next[k] = v_full[ACC_W-1:0];
            end
            v_run = w_next[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_acc[k] <= '0;
            end
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            for (int k = 0; k < STAGES; k++) begin
                r_acc[k] <= '0;
            end
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_acc[k] <= w_next[k];
                end
                r_ovf <= r_ovf | w_carry;
            end
        end
    end

    always_comb begin
        out = '0;
        if (32'(sel) < STAGES) begin
            out = r_acc[sel];
        end
    end

    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_acc_chain.sv
// Directed bench for acc_chain: a wrap-mode and a saturating instance share stimulus;
// table vectors cover the basic ripple/hold/clear, hand sequences cover overflow and reset.
module tb_acc_chain;

    localparam int DIN_W  = 4;
    localparam int ACC_W  = 8;
    localparam int STAGES = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [DIN_W-1:0] data = '0;
    logic             clr = 1'b0;
    logic [1:0]       sel = '0;

    logic [ACC_W-1:0]  w_out, s_out;
    logic              w_ov, s_ov;
    logic [STAGES-1:0] w_ovf, s_ovf;

    int total = 0;
    int bad   = 0;
    logic [ACC_W-1:0] exp_q[$];

    typedef struct {
        logic             iv;
        logic [DIN_W-1:0] d;
        logic             c;
        int               e0, e1, e2;
        logic             eov;
        logic [2:0]       eovf;
    } vec_t;

    vec_t vecs[12];

    acc_chain #(.DIN_W(DIN_W), .ACC_W(ACC_W), .STAGES(STAGES), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .clr(clr),
        .sel(sel), .out(w_out), .out_valid(w_ov), .ovf(w_ovf)
    );

    acc_chain #(.DIN_W(DIN_W), .ACC_W(ACC_W), .STAGES(STAGES), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data(data), .clr(clr),
        .sel(sel), .out(s_out), .out_valid(s_ov), .ovf(s_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs at the falling edge, return just after the rising edge
    task automatic step(input logic iv, input logic [DIN_W-1:0] d, input logic c);
        @(negedge clk);
        in_valid = iv;
        data     = d;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    // scoreboard: read every stage through sel on both instances
    task automatic check_stages(input string name, input int e0, input int e1, input int e2,
                                input logic eov, input logic [2:0] eovf);
        logic [ACC_W-1:0] e;
        exp_q.push_back(ACC_W'(e0));
        exp_q.push_back(ACC_W'(e1));
        exp_q.push_back(ACC_W'(e2));
        for (int k = 0; k < STAGES; k++) begin
            sel = 2'(k);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s wrap acc%0d", name, k), w_out, e);
            chk($sformatf("%s sat acc%0d", name, k), s_out, e);
        end
        chk({name, " wrap out_valid"}, w_ov, eov);
        chk({name, " sat out_valid"}, s_ov, eov);
        chk({name, " wrap ovf"}, w_ovf, eovf);
        chk({name, " sat ovf"}, s_ovf, eovf);
    endtask

    initial begin
        // ramp of ones, hold, clear-with-valid, then a fresh small ramp
        vecs[0]  = '{1'b1, 4'd1, 1'b0, 1, 1, 1, 1'b1, 3'b000};
        vecs[1]  = '{1'b1, 4'd1, 1'b0, 2, 3, 4, 1'b1, 3'b000};
        vecs[2]  = '{1'b1, 4'd1, 1'b0, 3, 6, 10, 1'b1, 3'b000};
        vecs[3]  = '{1'b0, 4'd9, 1'b0, 3, 6, 10, 1'b0, 3'b000};
        vecs[4]  = '{1'b0, 4'd9, 1'b0, 3, 6, 10, 1'b0, 3'b000};
        vecs[5]  = '{1'b0, 4'd9, 1'b0, 3, 6, 10, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 4'd9, 1'b0, 3, 6, 10, 1'b0, 3'b000};
        vecs[7]  = '{1'b0, 4'd9, 1'b0, 3, 6, 10, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 4'd7, 1'b1, 0, 0, 0, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 4'd5, 1'b0, 5, 5, 5, 1'b1, 3'b000};
        vecs[10] = '{1'b1, 4'd0, 1'b0, 5, 10, 15, 1'b1, 3'b000};
        vecs[11] = '{1'b0, 4'd3, 1'b1, 0, 0, 0, 1'b0, 3'b000};

        // reset state while reset is held low
        repeat (2) @(posedge clk);
        #1;
        check_stages("reset", 0, 0, 0, 1'b0, 3'b000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].c);
            check_stages($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2,
                         vecs[i].eov, vecs[i].eovf);
            if (i == 7) begin
                sel = 2'd3;
                #1;
                chk("sel3 wrap out", w_out, 0);
                chk("sel3 sat out", s_out, 0);
            end
        end

        // overflow of stage 0 with data=15: 17 edges reach 255, the 18th overflows
        for (int n = 1; n <= 18; n++) begin
            step(1'b1, 4'd15, 1'b0);
            if (n == 17) begin
                sel = 2'd0;
                #1;
                chk("e17 wrap acc0", w_out, 255);
                chk("e17 sat acc0", s_out, 255);
                chk("e17 wrap ovf", w_ovf, 3'b110);
                chk("e17 sat ovf", s_ovf, 3'b110);
            end
        end
        for (int k = 0; k < STAGES; k++) begin
            sel = 2'(k);
            #1;
            chk($sformatf("e18 wrap acc%0d", k), w_out, (k == 0) ? 14 : (k == 1) ? 5 : 204);
            chk($sformatf("e18 sat acc%0d", k), s_out, 255);
        end
        chk("e18 wrap ovf", w_ovf, 3'b111);
        chk("e18 sat ovf", s_ovf, 3'b111);

        // overflow flags stay set while idle
        step(1'b0, 4'd0, 1'b0);
        chk("sticky wrap ovf", w_ovf, 3'b111);
        chk("sticky sat ovf", s_ovf, 3'b111);

        // asynchronous reset between edges while acc2=10
        step(1'b0, 4'd0, 1'b1);
        repeat (3) step(1'b1, 4'd1, 1'b0);
        check_stages("pre-reset", 3, 6, 10, 1'b1, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        sel   = 2'd2;
        #1;
        chk("async reset wrap out", w_out, 0);
        chk("async reset sat out", s_out, 0);
        chk("async reset out_valid", w_ov, 0);
        #1;
        reset = 1'b1;
        step(1'b1, 4'd2, 1'b0);
        check_stages("post-reset", 2, 2, 2, 1'b1, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
